// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller.
// 1024 lines x 128 bits. Byte address split: tag[31:14], index[13:4], word[3:2].
// One CPU request is outstanding at a time. Misses go to a line-granular memory port.

package cache_def;
    localparam int TAG_W  = 18;
    localparam int IDX_W  = 10;
    localparam int LINES  = 1024;
    localparam int LINE_W = 128;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } cache_tag_t;
endpackage

// Tag store: combinational read, synchronous write, no reset (contents survive rst).
module dm_cache_tag
    import cache_def::*;
(
    input  logic             clk_i,
    input  logic [IDX_W-1:0] index_i,
    input  logic             we_i,
    input  cache_tag_t       wdata_i,
    output cache_tag_t       rdata_o
);
    cache_tag_t tag_mem_q [0:LINES-1];

    // Write the addressed tag entry when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_mem_q[index_i] <= wdata_i;
        end
    end

    assign rdata_o = tag_mem_q[index_i];
endmodule

// Data store: combinational read, synchronous full-line write, no reset.
module dm_cache_data
    import cache_def::*;
(
    input  logic              clk_i,
    input  logic [IDX_W-1:0]  index_i,
    input  logic              we_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);
    logic [LINE_W-1:0] data_mem_q [0:LINES-1];

    // Write the addressed line when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            data_mem_q[index_i] <= wdata_i;
        end
    end

    assign rdata_o = data_mem_q[index_i];
endmodule

module dm_cache_ctrl
    import cache_def::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_valid,
    input  logic          cpu_rw,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_ready,
    output logic [31:0]   cpu_rdata,
    output logic          mem_valid,
    output logic          mem_rw,
    output logic [31:0]   mem_addr,
    output logic [127:0]  mem_wdata,
    input  logic          mem_ready,
    input  logic [127:0]  mem_rdata
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        WRITE_BACK = 2'd2,
        ALLOCATE   = 2'd3
    } state_e;

    state_e       state_q, state_d;
    logic         req_rw_q, req_rw_d;
    logic [31:2]  req_addr_q, req_addr_d;
    logic [31:0]  req_wdata_q, req_wdata_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [127:0] mem_wdata_q, mem_wdata_d;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [1:0]       req_off;

    cache_tag_t        tag_rd, tag_wr;
    logic              tag_we;
    logic [LINE_W-1:0] line_rd, line_wr;
    logic              data_we;
    logic              hit;

    // Byte-lane bits never reach the arrays; they are accepted and dropped.
    logic unused_byte_bits;
    assign unused_byte_bits = ^cpu_addr[1:0];

    assign req_tag = req_addr_q[31:14];
    assign req_idx = req_addr_q[13:4];
    assign req_off = req_addr_q[3:2];

    // Both arrays are always addressed by the latched request's index.
    dm_cache_tag u_tag (
        .clk_i   (clk),
        .index_i (req_idx),
        .we_i    (tag_we),
        .wdata_i (tag_wr),
        .rdata_o (tag_rd)
    );

    dm_cache_data u_data (
        .clk_i   (clk),
        .index_i (req_idx),
        .we_i    (data_we),
        .wdata_i (line_wr),
        .rdata_o (line_rd)
    );

    assign hit = tag_rd.valid && (tag_rd.tag == req_tag);

    // State and request/memory-side registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_rw_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_rw_q    <= req_rw_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next-state logic, request latch and memory address/victim capture.
    always_comb begin
        state_d     = state_q;
        req_rw_d    = req_rw_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_valid) begin
                    req_rw_d    = cpu_rw;
                    req_addr_d  = cpu_addr[31:2];
                    req_wdata_d = cpu_wdata;
                    state_d     = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    state_d = IDLE;
                end else if (tag_rd.valid && tag_rd.dirty) begin
                    mem_addr_d  = {tag_rd.tag, req_idx, 4'b0000};
                    mem_wdata_d = line_rd;
                    state_d     = WRITE_BACK;
                end else begin
                    mem_addr_d = {req_tag, req_idx, 4'b0000};
                    state_d    = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                if (mem_ready) begin
                    mem_addr_d = {req_tag, req_idx, 4'b0000};
                    state_d    = ALLOCATE;
                end
            end
            ALLOCATE: begin
                // The fill returns to COMPARE so the replay takes the hit path.
                if (mem_ready) begin
                    state_d = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and array write enables, decoded from the current state.
    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        mem_valid = 1'b0;
        mem_rw    = 1'b0;
        tag_we    = 1'b0;
        tag_wr    = '0;
        data_we   = 1'b0;
        line_wr   = line_rd;
        case (state_q)
            COMPARE: begin
                if (hit) begin
                    cpu_ready = 1'b1;
                    if (req_rw_q) begin
                        line_wr[{req_off, 5'b00000} +: 32] = req_wdata_q;
                        data_we      = 1'b1;
                        tag_we       = 1'b1;
                        tag_wr.valid = 1'b1;
                        tag_wr.dirty = 1'b1;
                        tag_wr.tag   = req_tag;
                    end else begin
                        cpu_rdata = line_rd[{req_off, 5'b00000} +: 32];
                    end
                end
            end
            WRITE_BACK: begin
                mem_valid = 1'b1;
                mem_rw    = 1'b1;
            end
            ALLOCATE: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    data_we      = 1'b1;
                    line_wr      = mem_rdata;
                    tag_we       = 1'b1;
                    tag_wr.valid = 1'b1;
                    tag_wr.dirty = 1'b0;
                    tag_wr.tag   = req_tag;
                end
            end
            default: begin
            end
        endcase
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: a cache/memory reference model predicts
// CPU responses and memory requests; separate monitors compare what the DUT shows.
module tb_dm_cache_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_valid, cpu_rw;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic         mem_valid, mem_rw;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    dm_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic        rw;
        logic [31:0] rdata;
        bit          hit;
        bit          dirty_miss;
        int          acc;
    } cpu_exp_t;

    mem_exp_t mem_q[$];
    cpu_exp_t cpu_q[$];

    // Reference cache contents and two memory images (model side / responder side).
    logic         m_valid [1024];
    logic         m_dirty [1024];
    logic [17:0]  m_tag   [1024];
    logic [127:0] m_data  [1024];
    logic [127:0] ref_mem [logic [27:0]];
    logic [127:0] mem_img [logic [27:0]];

    int force_delay = -1;
    bit mem_hold    = 1'b0;
    bit force_stray = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] init_line(input logic [27:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++)
            l[w*32 +: 32] = {la, 4'h0} ^ (32'h9E37_79B9 * (w + 1)) ^ 32'h0F0F_0000;
        return l;
    endfunction

    function automatic logic [127:0] ref_fetch(input logic [27:0] la);
        return ref_mem.exists(la) ? ref_mem[la] : init_line(la);
    endfunction

    function automatic logic [127:0] img_fetch(input logic [27:0] la);
        return mem_img.exists(la) ? mem_img[la] : init_line(la);
    endfunction

    // Apply one request to the reference cache and queue the expected traffic.
    task automatic model_req(input logic rw, input logic [31:0] addr,
                             input logic [31:0] wdata, output cpu_exp_t e);
        int          idx;
        int          off;
        logic [17:0] tg;
        idx = int'(addr[13:4]);
        off = int'(addr[3:2]);
        tg  = addr[31:14];
        e.rw         = rw;
        e.hit        = m_valid[idx] && (m_tag[idx] == tg);
        e.dirty_miss = 1'b0;
        e.rdata      = '0;
        if (!e.hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                mem_q.push_back('{rw: 1'b1, addr: {m_tag[idx], addr[13:4], 4'h0}, wdata: m_data[idx]});
                ref_mem[{m_tag[idx], addr[13:4]}] = m_data[idx];
                e.dirty_miss = 1'b1;
            end
            mem_q.push_back('{rw: 1'b0, addr: {tg, addr[13:4], 4'h0}, wdata: 128'h0});
            m_data[idx]  = ref_fetch({tg, addr[13:4]});
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        if (rw) begin
            m_data[idx][off*32 +: 32] = wdata;
            m_dirty[idx] = 1'b1;
        end else begin
            e.rdata = m_data[idx][off*32 +: 32];
        end
    endtask

    // Issue one CPU request and wait (bounded) for its completion pulse.
    task automatic issue(input logic rw, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit hold);
        cpu_exp_t e;
        int       start_done;
        bit       got;
        @(negedge clk);
        model_req(rw, addr, wdata, e);
        e.acc = cyc;
        cpu_q.push_back(e);
        start_done = done_cnt;
        cpu_valid = 1'b1;
        cpu_rw    = rw;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        if (!hold) begin
            @(negedge clk);
            cpu_valid = 1'b0;
            cpu_rw    = 1'($urandom);
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
        end
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != start_done) got = 1'b1;
        end
        cpu_valid = 1'b0;
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cpu_timeout: addr %h no cpu_ready within 100 cycles", addr);
            cpu_q.delete();
        end
    endtask

    // CPU-side monitor: every ready pulse must match the oldest expected response.
    cpu_exp_t ce;
    int       lat;
    always @(negedge clk) begin
        if (cpu_ready) begin
            if (cpu_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_cpu_ready: got ready=1 expected no pending request");
            end else begin
                ce  = cpu_q.pop_front();
                lat = cyc - ce.acc;
                if (!ce.rw) chk("cpu_rdata", {96'h0, cpu_rdata}, {96'h0, ce.rdata});
                n_cmp++;
                if (ce.hit ? (lat != 1) : (lat < (ce.dirty_miss ? 4 : 3))) begin
                    n_fail++;
                    $display("FAIL cpu_latency: got %0d cycles expected %s (hit=%0d dirty=%0d)",
                             lat, ce.hit ? "1" : "minimum miss", ce.hit, ce.dirty_miss);
                end
            end
            done_cnt++;
        end
    end

    // Memory responder and monitor: checks each request, its stability, and answers it.
    mem_exp_t me;
    mem_exp_t snap;
    bit       started = 1'b0;
    bit       prev_rdy;
    int       delay = 0;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            prev_rdy  = mem_ready;
            mem_ready = 1'b0;
            if (!mem_valid || prev_rdy) started = 1'b0;
            if (mem_valid) begin
                if (!started) begin
                    started = 1'b1;
                    snap = '{rw: mem_rw, addr: mem_addr, wdata: mem_wdata};
                    delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                    if (mem_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_mem_req: got rw=%0d addr=%h expected none",
                                 mem_rw, mem_addr);
                    end else begin
                        me = mem_q.pop_front();
                        chk("mem_rw", {127'h0, mem_rw}, {127'h0, me.rw});
                        chk("mem_addr", {96'h0, mem_addr}, {96'h0, me.addr});
                        if (me.rw) chk("mem_wdata", mem_wdata, me.wdata);
                    end
                end else begin
                    chk("mem_stable_addr", {95'h0, mem_rw, mem_addr}, {95'h0, snap.rw, snap.addr});
                    if (snap.rw) chk("mem_stable_wdata", mem_wdata, snap.wdata);
                end
                if (delay == 0) begin
                    if (!mem_hold) begin
                        mem_ready = 1'b1;
                        if (mem_rw) mem_img[mem_addr[31:4]] = mem_wdata;
                        else        mem_rdata = img_fetch(mem_addr[31:4]);
                    end
                end else begin
                    delay--;
                end
            end else if (force_stray || ($urandom_range(0, 7) == 0)) begin
                mem_ready = 1'b1;
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1);
    end

    logic [127:0] l1;
    logic [17:0]  rtg;
    logic [9:0]   ridx;
    bit           seen;
    initial begin
        for (int i = 0; i < 1024; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
            m_data[i]  = '0;
        end
        cpu_valid = 1'b0;
        cpu_rw    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        rst = 1'b1;
        #1;
        chk("rst_cpu_ready", {127'h0, cpu_ready}, 128'h0);
        chk("rst_cpu_rdata", {96'h0, cpu_rdata}, 128'h0);
        chk("rst_mem_valid", {127'h0, mem_valid}, 128'h0);
        chk("rst_mem_rw",    {127'h0, mem_rw}, 128'h0);
        chk("rst_mem_addr",  {96'h0, mem_addr}, 128'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        l1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        ref_mem[28'h1] = l1;
        mem_img[28'h1] = l1;

        // Cold miss, write hit, read-back, dirty eviction with a slow memory, clean miss.
        force_delay = 2;
        issue(1'b0, 32'h0000_0014, 32'h0, 1'b0);
        force_delay = -1;
        issue(1'b1, 32'h0000_0018, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 32'h0000_0018, 32'h0, 1'b0);
        force_delay = 3;
        issue(1'b0, 32'h0000_4010, 32'h0, 1'b0);
        force_delay = -1;
        issue(1'b0, 32'h0000_8010, 32'h0, 1'b1);

        // Stray memory handshakes while idle must not wake anything up.
        @(negedge clk);
        force_stray = 1'b1;
        repeat (3) @(negedge clk);
        force_stray = 1'b0;
        #1;
        chk("stray_mem_valid", {127'h0, mem_valid}, 128'h0);
        chk("stray_cpu_ready", {127'h0, cpu_ready}, 128'h0);

        // Reset while a fill is outstanding: request dropped, line 1 keeps tag 2.
        mem_hold = 1'b1;
        @(negedge clk);
        mem_q.push_back('{rw: 1'b0, addr: 32'h0000_C010, wdata: 128'h0});
        cpu_valid = 1'b1;
        cpu_rw    = 1'b0;
        cpu_addr  = 32'h0000_C010;
        @(negedge clk);
        cpu_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_valid) seen = 1'b1;
        end
        chk("abandon_fill_started", {127'h0, seen}, 128'h1);
        #2 rst = 1'b1;
        #1;
        chk("abandon_mem_valid", {127'h0, mem_valid}, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_hold = 1'b0;
        issue(1'b0, 32'h0000_8010, 32'h0, 1'b0);
        issue(1'b0, 32'h0000_C014, 32'h0, 1'b0);

        // Randomized traffic over a small tag/index window to force conflicts.
        for (int n = 0; n < 400; n++) begin
            rtg  = 18'($urandom_range(0, 3));
            ridx = 10'($urandom_range(0, 7));
            issue(1'($urandom), {rtg, ridx, 2'($urandom), 2'($urandom)}, $urandom,
                  ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge clk);
        chk("cpu_queue_drained", 128'(cpu_q.size()), 128'h0);
        chk("mem_queue_drained", 128'(mem_q.size()), 128'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
